// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared state encoding and default sizes for reg_file_pp
package rf_pkg;

  localparam int RF_WIDTH_DEF  = 32;
  localparam int RF_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'b00,
    RF_CLEAR = 2'b01,
    RF_DONE  = 2'b10
  } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - clear-all sequencer: walks every entry once, then pulses done
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              idle
);

  rf_state_e         state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  // State and pointer registers; reset abandons any clear in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RF_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state and outputs; the pointer wraps to 0 on the last entry.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    busy      = 1'b0;
    clr_done  = 1'b0;
    clr_we    = 1'b0;
    idle      = 1'b0;
    unique case (state)
      RF_IDLE: begin
        idle = 1'b1;
        if (clr_req) begin
          state_nxt = RF_CLEAR;
          ptr_nxt   = '0;
        end
      end
      RF_CLEAR: begin
        busy    = 1'b1;
        clr_we  = 1'b1;
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == {ADDR_W{1'b1}}) state_nxt = RF_DONE;
      end
      RF_DONE: begin
        clr_done  = 1'b1;
        state_nxt = RF_IDLE;
      end
      default: state_nxt = RF_IDLE;
    endcase
  end

  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_pp.sv
// rtl/reg_file_pp.sv - WIDTH x 2**ADDR_W register file, 2 async reads, 1 write, clear sequencer; option REG_FILE_BYPASS_EN
module reg_file_pp
  import rf_pkg::*;
#(
  parameter int               WIDTH         = RF_WIDTH_DEF,
  parameter int               ADDR_W        = RF_ADDR_W_DEF,
  parameter logic [WIDTH-1:0] RESET_PATTERN = {WIDTH{1'b0}},
  parameter int               ZERO_REG      = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic [ADDR_W-1:0] RD_ADDR1,
  output logic [WIDTH-1:0]  RD_DATA1,
  input  logic [ADDR_W-1:0] RD_ADDR2,
  output logic [WIDTH-1:0]  RD_DATA2,
  input  logic              CLR_REQ,
  output logic              BUSY,
  output logic              CLR_DONE
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              idle;
  logic              user_we;

  rf_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk      (CLK),
    .reset    (RESET),
    .clr_req  (CLR_REQ),
    .busy     (BUSY),
    .clr_done (CLR_DONE),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .idle     (idle)
  );

  // User writes only land in IDLE; entry 0 is read-only when hardwired to zero.
  assign user_we = idle && WR_EN && !((ZERO_REG != 0) && (WR_ADDR == '0));

`ifdef REG_FILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = idle && !RESET && WR_EN;
`endif

  // Storage: reset fills the pattern, clear walker beats the user port.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_PATTERN;
    end else if (clr_we) begin
      mem[clr_addr] <= RESET_PATTERN;
    end else if (user_we) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  // Read port 1: stored value, optional forwarding, zero-entry mask last.
  always_comb begin
    RD_DATA1 = mem[RD_ADDR1];
`ifdef REG_FILE_BYPASS_EN
    if (fwd_ok && (WR_ADDR == RD_ADDR1)) RD_DATA1 = WR_DATA;
`endif
    if ((ZERO_REG != 0) && (RD_ADDR1 == '0)) RD_DATA1 = '0;
  end

  // Read port 2: same structure as port 1.
  always_comb begin
    RD_DATA2 = mem[RD_ADDR2];
`ifdef REG_FILE_BYPASS_EN
    if (fwd_ok && (WR_ADDR == RD_ADDR2)) RD_DATA2 = WR_DATA;
`endif
    if ((ZERO_REG != 0) && (RD_ADDR2 == '0)) RD_DATA2 = '0;
  end

endmodule

// File: tb/tb_reg_file_pp.sv
// tb/tb_reg_file_pp.sv - scoreboard bench for reg_file_pp (zero-reg and plain instances share stimulus)
module tb_reg_file_pp;

  localparam logic [31:0] PAT_A = 32'hFFFF_FFFF;
  localparam logic [31:0] PAT_B = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        clr_req;
  logic [31:0] rd_data1, rd_data2, b_rd_data1, b_rd_data2;
  logic        busy, clr_done, b_busy, b_clr_done;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  reg_file_pp #(.WIDTH(32), .ADDR_W(5), .RESET_PATTERN(PAT_A), .ZERO_REG(1)) dut (
    .CLK(clk), .RESET(reset), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .RD_ADDR1(rd_addr1), .RD_DATA1(rd_data1), .RD_ADDR2(rd_addr2), .RD_DATA2(rd_data2),
    .CLR_REQ(clr_req), .BUSY(busy), .CLR_DONE(clr_done)
  );

  reg_file_pp #(.WIDTH(32), .ADDR_W(5), .RESET_PATTERN(PAT_B), .ZERO_REG(0)) dut_b (
    .CLK(clk), .RESET(reset), .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
    .RD_ADDR1(rd_addr1), .RD_DATA1(b_rd_data1), .RD_ADDR2(rd_addr2), .RD_DATA2(b_rd_data2),
    .CLR_REQ(clr_req), .BUSY(b_busy), .CLR_DONE(b_clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr1 = '0; rd_addr2 = '0; clr_req = 1'b0;
    step(); step();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    step();
    wr_en = 1'b0; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
    #1;
    push("pre_reset_e5", 32'hDEAD_BEEF);
    e = sb.pop_front(); vectors++;
    if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    push("reset_e5_a", PAT_A);
    push("reset_e5_b", PAT_B);
    push("reset_busy", 32'd0);
    push("reset_done", 32'd0);
    e = sb.pop_front(); vectors++;
    if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
    e = sb.pop_front(); vectors++;
    if (b_rd_data2 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, b_rd_data2, e.val); end
    e = sb.pop_front(); vectors++;
    if ({31'd0, busy} !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, busy, e.val); end
    e = sb.pop_front(); vectors++;
    if ({31'd0, clr_done} !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, clr_done, e.val); end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678; rd_addr1 = 5'd7;
    #1;
`ifdef REG_FILE_BYPASS_EN
    push("same_cycle_e7", 32'h1234_5678);
`else
    push("same_cycle_e7", PAT_A);
`endif
    e = sb.pop_front(); vectors++;
    if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
    step();
    wr_addr = 5'd31; wr_data = 32'hCAFE_F00D;
    step();
    wr_en = 1'b0; rd_addr1 = 5'd7; rd_addr2 = 5'd31;
    #1;
    push("read_e7", 32'h1234_5678);
    push("read_e31", 32'hCAFE_F00D);
    e = sb.pop_front(); vectors++;
    if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
    e = sb.pop_front(); vectors++;
    if (rd_data2 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data2, e.val); end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hAAAA_5555; rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    #1;
    push("zero_same_a", 32'h0);
`ifdef REG_FILE_BYPASS_EN
    push("zero_same_b", 32'hAAAA_5555);
`else
    push("zero_same_b", PAT_B);
`endif
    e = sb.pop_front(); vectors++;
    if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
    e = sb.pop_front(); vectors++;
    if (b_rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, b_rd_data1, e.val); end
    step();
    wr_en = 1'b0;
    #1;
    push("zero_after_a", 32'h0);
    push("zero_after_b", 32'hAAAA_5555);
    e = sb.pop_front(); vectors++;
    if (rd_data2 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data2, e.val); end
    e = sb.pop_front(); vectors++;
    if (b_rd_data2 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, b_rd_data2, e.val); end
  endtask

  task automatic test_clear();
    int busy_n, done_n, done_at;
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i);
      step();
    end
    wr_en = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int s = 0; s < 40; s++) begin
      rd_addr1 = 5'd15; rd_addr2 = 5'd16;
      #1;
      if (busy) busy_n++;
      if (clr_done) begin done_n++; done_at = s; end
      if (s == 16) begin
        push("mid_e15", PAT_A);
        push("mid_e16", 32'd16);
        e = sb.pop_front(); vectors++;
        if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
        e = sb.pop_front(); vectors++;
        if (rd_data2 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data2, e.val); end
      end
      step();
    end
    push("clr_busy_cycles", 32'd32);
    push("clr_done_pulses", 32'd1);
    push("clr_done_cycle", 32'd32);
    e = sb.pop_front(); vectors++;
    if (32'(busy_n) !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, busy_n, e.val); end
    e = sb.pop_front(); vectors++;
    if (32'(done_n) !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, done_n, e.val); end
    e = sb.pop_front(); vectors++;
    if (32'(done_at) !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, done_at, e.val); end
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i); rd_addr2 = 5'(i);
      #1;
      push($sformatf("cleared_a_e%0d", i), (i == 0) ? 32'h0 : PAT_A);
      push($sformatf("cleared_b_e%0d", i), PAT_B);
      e = sb.pop_front(); vectors++;
      if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
      e = sb.pop_front(); vectors++;
      if (b_rd_data2 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, b_rd_data2, e.val); end
    end
  endtask

  task automatic test_ignored_inputs();
    int busy_n, done_n;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_n = 0; done_n = 0;
    for (int s = 0; s < 40; s++) begin
      if (s == 5) begin
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1; clr_req = 1'b1; rd_addr1 = 5'd3;
      end else begin
        wr_en = 1'b0; clr_req = 1'b0;
      end
      #1;
      if (busy) busy_n++;
      if (clr_done) done_n++;
      if (s == 5) begin
        push("clear_no_fwd_e3", PAT_A);
        e = sb.pop_front(); vectors++;
        if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
      end
      step();
    end
    wr_en = 1'b0; clr_req = 1'b0; rd_addr1 = 5'd3;
    #1;
    push("ignored_wr_e3", PAT_A);
    push("ignored_busy_cycles", 32'd32);
    push("ignored_done_pulses", 32'd1);
    e = sb.pop_front(); vectors++;
    if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
    e = sb.pop_front(); vectors++;
    if (32'(busy_n) !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, busy_n, e.val); end
    e = sb.pop_front(); vectors++;
    if (32'(done_n) !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, done_n, e.val); end
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0077;
    step();
    wr_en = 1'b0;
    #1;
    push("idle_write_e3", 32'h0000_0077);
    e = sb.pop_front(); vectors++;
    if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
  endtask

  task automatic test_reset_mid_clear();
    int busy_n, done_n;
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h0000_1234;
    step();
    wr_addr = 5'd5; wr_data = 32'h0000_0055;
    step();
    wr_en = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int s = 0; s < 9; s++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    done_n = 0;
    rd_addr1 = 5'd20; rd_addr2 = 5'd5;
    #1;
    push("midreset_busy", 32'd0);
    push("midreset_e20", PAT_A);
    push("midreset_e5", PAT_A);
    e = sb.pop_front(); vectors++;
    if ({31'd0, busy} !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, busy, e.val); end
    e = sb.pop_front(); vectors++;
    if (rd_data1 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data1, e.val); end
    e = sb.pop_front(); vectors++;
    if (rd_data2 !== e.val) begin miscompares++; $display("FAIL %s: observed %h expected %h", e.tag, rd_data2, e.val); end
    for (int s = 0; s < 30; s++) begin
      #1;
      if (clr_done) done_n++;
      step();
    end
    push("midreset_no_done", 32'd0);
    e = sb.pop_front(); vectors++;
    if (32'(done_n) !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, done_n, e.val); end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_n = 0; done_n = 0;
    for (int s = 0; s < 40; s++) begin
      #1;
      if (busy) busy_n++;
      if (clr_done) done_n++;
      step();
    end
    push("reclear_busy_cycles", 32'd32);
    push("reclear_done_pulses", 32'd1);
    e = sb.pop_front(); vectors++;
    if (32'(busy_n) !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, busy_n, e.val); end
    e = sb.pop_front(); vectors++;
    if (32'(done_n) !== e.val) begin miscompares++; $display("FAIL %s: observed %0d expected %0d", e.tag, done_n, e.val); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_clear();
    test_ignored_inputs();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_pp.md
Name: reg_file_pp

Overview:
- Parametrised multi-port register file for the processor datapath; generalises the fixed 32-bit pattern-preset register to WIDTH x DEPTH storage.
- Two asynchronous read ports, one synchronous write port, configurable reset pattern, optional hardwired-zero entry 0.
- Built-in clear sequencer: on request, rewrites every entry to the reset pattern, one entry per cycle, with BUSY/CLR_DONE handshake.
- Sits between instruction decode (read addresses) and writeback (write port).

Parameters:
- WIDTH, 32, data bits per entry.
- ADDR_W, 5, address bits; DEPTH = 2**ADDR_W entries (32).
- RESET_PATTERN, {WIDTH{1'b0}}, value loaded into every entry by RESET or by a clear sequence.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is ordinary storage.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- WR_EN  input  1  write enable.
- WR_ADDR  input  ADDR_W  write address.
- WR_DATA  input  WIDTH  write data.
- RD_ADDR1  input  ADDR_W  read port 1 address.
- RD_DATA1  output  WIDTH  read port 1 data (combinational).
- RD_ADDR2  input  ADDR_W  read port 2 address.
- RD_DATA2  output  WIDTH  read port 2 data (combinational).
- CLR_REQ  input  1  clear-all request, sampled only in IDLE.
- BUSY  output  1  clear sequence in progress.
- CLR_DONE  output  1  one-cycle pulse when a clear sequence completes.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high on RESET.
- Reset (RESET=1 at a rising edge):
  - all entries <= RESET_PATTERN; state <= IDLE; clear pointer <= 0.
  - BUSY=0, CLR_DONE=0.
  - RESET overrides WR_EN, CLR_REQ and any in-progress clear.
- Reads:
  - RD_DATAx = entry[RD_ADDRx], combinational, no latency.
  - With ZERO_REG=1, address 0 returns {WIDTH{1'b0}} regardless of RESET_PATTERN.
- Writes:
  - In IDLE with WR_EN=1: entry[WR_ADDR] <= WR_DATA at the edge; visible on reads the cycle after.
  - Writes to address 0 are dropped when ZERO_REG=1.
- State machine, states IDLE, CLEAR, DONE:
  - IDLE: CLR_REQ=1 at an edge -> CLEAR, pointer <= 0. A WR_EN in that same cycle still commits.
  - CLEAR: BUSY=1. Each edge: entry[pointer] <= RESET_PATTERN, pointer++. The edge that writes entry DEPTH-1 -> DONE, pointer wraps to 0.
  - DONE: BUSY=0, CLR_DONE=1 for exactly one cycle; next edge -> IDLE.
- Clear-sequence rules:
  - WR_EN is ignored in CLEAR and DONE (write lost, no error flag).
  - CLR_REQ is ignored in CLEAR and DONE (no queuing).
  - Reads during CLEAR return current contents: entries below the pointer are cleared, the rest are stale.
- Clear timing for DEPTH=32:
  - CLR_REQ sampled at edge E0.
  - BUSY high from after E0 until after E32.
  - Entries 0..31 cleared at E1..E32.
  - CLR_DONE high in the cycle between E32 and E33; IDLE after E33.
- Widths: all data paths are WIDTH bits, no truncation or extension. The pointer is ADDR_W bits and wraps naturally.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: in IDLE, if WR_EN=1 and WR_ADDR==RD_ADDRx, then RD_DATAx = WR_DATA in the same cycle (write-through forwarding).
  - Forwarding is suppressed for address 0 when ZERO_REG=1.
  - Forwarding is suppressed in CLEAR/DONE and while RESET=1.
- Not defined: reads always return stored contents; a written value appears only after the edge.

Decomposition:
- Shared definitions package (rf_pkg):
  - state encoding constants RF_IDLE=2'b00, RF_CLEAR=2'b01, RF_DONE=2'b10.
  - default WIDTH/ADDR_W constants.
- Sub-module rf_clear_seq: FSM plus pointer. Outputs BUSY, CLR_DONE, clear write-enable and clear address. The top level muxes the clear write against the user write port.
- Storage array and read muxes stay in reg_file_pp.

Test Plan:
- Reset: write 0xDEADBEEF to entry 5, assert RESET one cycle -> RD_DATA1(addr 5)=RESET_PATTERN, BUSY=0, CLR_DONE=0.
- Write/read: write 0x12345678 to addr 7, 0xCAFEF00D to addr 31 -> next cycle RD_DATA1(7)=0x12345678, RD_DATA2(31)=0xCAFEF00D. Same-cycle read of addr 7 shows the old value without bypass and 0x12345678 with REG_FILE_BYPASS_EN.
- Zero reg: ZERO_REG=1, RESET_PATTERN=0xFFFFFFFF, write 0xAAAA5555 to addr 0 -> RD_DATA1(0)=0x00000000 always; with ZERO_REG=0 it reads 0xAAAA5555.
- Clear sequence: fill all 32 entries with their index, pulse CLR_REQ at E0 -> BUSY high for 32 cycles. After E16, entry 15=pattern and entry 16=16. CLR_DONE single pulse after E32; all entries=pattern.
- Ignored inputs: WR_EN (addr 3, 0x1) and a second CLR_REQ during CLEAR -> entry 3 ends at pattern; exactly one CLR_DONE pulse; FSM back in IDLE after E33.
- Reset mid-clear: assert RESET at E10 of a clear -> BUSY=0 next cycle, no CLR_DONE, all entries=pattern; a new CLR_REQ then completes normally.
